// File: rtl/fst_run_pkg.sv
// fst_run_pkg: shared state encoding and default sizes for the fst run controller
package fst_run_pkg;
  typedef enum logic [2:0] {IDLE, RESET, RUN, HALT, TMO} run_state_t;
  localparam int FST_CNT_W = 32;
  localparam logic [31:0] FST_DEFAULT_TIMEOUT = 32'h000F_FFFF;
endpackage

// File: rtl/fst_run_ctrl_if.sv
// fst_run_ctrl_if: host/core-side signal bundle of the run controller; pc/halt_pc exist only with FST_RUN_CTRL_PC_TRACE_EN
interface fst_run_ctrl_if import fst_run_pkg::*; #(parameter int CNT_W = FST_CNT_W);
  logic start;
  logic timeout_ld;
  logic [CNT_W-1:0] timeout_val;
  logic is_halt;
  logic core_reset_n;
  logic busy;
  logic done;
  logic halted;
  logic timed_out;
  logic [CNT_W-1:0] cycles;
`ifdef FST_RUN_CTRL_PC_TRACE_EN
  logic [31:0] pc;
  logic [31:0] halt_pc;
`endif
  modport master (
    output start, timeout_ld, timeout_val, is_halt,
`ifdef FST_RUN_CTRL_PC_TRACE_EN
    output pc, input halt_pc,
`endif
    input core_reset_n, busy, done, halted, timed_out, cycles
  );
  modport slave (
    input start, timeout_ld, timeout_val, is_halt,
`ifdef FST_RUN_CTRL_PC_TRACE_EN
    input pc, output halt_pc,
`endif
    output core_reset_n, busy, done, halted, timed_out, cycles
  );
endinterface

// File: rtl/fst_sat_counter.sv
// fst_sat_counter: clearable, enabled up-counter that sticks at all-ones
module fst_sat_counter #(parameter int CNT_W = 32) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic [CNT_W-1:0] q
);
  // count up while enabled, hold once every bit is set
  always_ff @(posedge clk)
    if (rst || clr) q <= '0;
    else if (en && !(&q)) q <= q + 1'b1;
endmodule

// File: rtl/fst_run_ctrl.sv
// fst_run_ctrl: holds the core in reset, runs it, and ends the run on halt or watchdog; FST_RUN_CTRL_PC_TRACE_EN adds halt_pc capture
module fst_run_ctrl import fst_run_pkg::*; #(
  parameter int RESET_CYCLES = 3,
  parameter int CNT_W = FST_CNT_W,
  parameter logic [CNT_W-1:0] DEFAULT_TIMEOUT = CNT_W'(FST_DEFAULT_TIMEOUT)
) (
  input logic clk,
  input logic reset,
  fst_run_ctrl_if.slave bus
);
  localparam int HW = RESET_CYCLES > 1 ? $clog2(RESET_CYCLES) : 1;
  run_state_t state;
  logic [HW-1:0] hold;
  logic [CNT_W-1:0] limit;
  logic accept, run_en, tmo_hit;
  assign accept = bus.start && (state == IDLE || state == HALT || state == TMO);
  assign run_en = state == RUN && !bus.is_halt;
  assign tmo_hit = limit != '0 && bus.cycles == limit - 1'b1;
  fst_sat_counter #(.CNT_W(CNT_W)) u_cycles (
    .clk(clk),
    .rst(reset),
    .clr(accept),
    .en(run_en),
    .q(bus.cycles)
  );
  // run FSM with registered status; halt is checked before the watchdog so it wins a tie
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      hold <= '0;
      limit <= DEFAULT_TIMEOUT;
      bus.core_reset_n <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.halted <= 1'b0;
      bus.timed_out <= 1'b0;
`ifdef FST_RUN_CTRL_PC_TRACE_EN
      bus.halt_pc <= '0;
`endif
    end else begin
      bus.done <= 1'b0;
      if (bus.timeout_ld) limit <= bus.timeout_val;
      case (state)
        IDLE, HALT, TMO:
          if (bus.start) begin
            state <= RESET;
            hold <= HW'(RESET_CYCLES - 1);
            bus.core_reset_n <= 1'b0;
            bus.busy <= 1'b1;
            bus.halted <= 1'b0;
            bus.timed_out <= 1'b0;
`ifdef FST_RUN_CTRL_PC_TRACE_EN
            bus.halt_pc <= '0;
`endif
          end
        RESET:
          if (hold == '0) begin
            state <= RUN;
            bus.core_reset_n <= 1'b1;
          end else hold <= hold - 1'b1;
        RUN:
          if (bus.is_halt || tmo_hit) begin
            state <= bus.is_halt ? HALT : TMO;
            bus.core_reset_n <= bus.is_halt;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            bus.halted <= bus.is_halt;
            bus.timed_out <= !bus.is_halt;
`ifdef FST_RUN_CTRL_PC_TRACE_EN
            bus.halt_pc <= bus.pc;
`endif
          end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/fst_run_ctrl.md
Name: fst_run_ctrl

Overview:
- Run controller for the fst core. Drives the core's active-low reset_n, releases it after a programmable hold, counts executed cycles and watches is_halt.
- Reports completion (halt) or watchdog timeout through a start/done handshake.
- Sits beside the core in the top level; the host/board logic (or bench) issues start and reads status.

Parameters:
- RESET_CYCLES, 3, cycles core_reset_n is held low after start (min 1)
- CNT_W, 32, width of cycle counter and timeout limit
- DEFAULT_TIMEOUT, 32'h000F_FFFF, timeout limit loaded at reset; 0 means no timeout

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high block reset
- start  in  1  request a run; accepted only in IDLE or a terminal state
- timeout_ld  in  1  load timeout_val into limit register (any state)
- timeout_val  in  CNT_W  new timeout limit
- is_halt  in  1  halt indication from core
- core_reset_n  out  1  active-low reset to the core
- busy  out  1  run in progress (RESET or RUN)
- done  out  1  single-cycle pulse when run ends
- halted  out  1  sticky: last run ended by halt
- timed_out  out  1  sticky: last run ended by watchdog
- cycles  out  CNT_W  cycles spent in RUN for the current/last run

Behaviour:
- Reset (reset=1 at clk edge): state IDLE; core_reset_n=0, busy=0, done=0, halted=0, timed_out=0, cycles=0, limit=DEFAULT_TIMEOUT, hold counter=0.
- States: IDLE, RESET, RUN, HALT, TMO.
- IDLE/HALT/TMO + start=1 -> RESET next cycle. On acceptance: clear halted, timed_out, cycles; load hold counter with RESET_CYCLES-1. start in RESET/RUN is ignored.
- RESET: core_reset_n=0, busy=1, hold counter decrements each cycle. At count 0 -> RUN. core_reset_n is exactly RESET_CYCLES cycles low after the start edge.
- RUN: core_reset_n=1, busy=1, cycles increments by 1 per cycle. Saturates at all-ones; no wrap.
- RUN and is_halt=1 -> HALT. halted=1 and done pulses in the cycle HALT is entered. cycles does not count the halt cycle.
- RUN and limit!=0 and cycles==limit-1 and is_halt=0 -> TMO. timed_out=1, done pulse, cycles==limit.
- Halt and timeout in the same cycle: halt wins (halted=1, timed_out=0).
- HALT: core_reset_n stays 1 so core state is inspectable; busy=0.
- TMO: core_reset_n driven 0 (core frozen); busy=0.
- is_halt is ignored outside RUN, including a stale halt held during RESET.
- timeout_ld mid-run takes effect next cycle. A new limit <= cycles cannot fire (equality compare only); the run continues until halt or saturation.
- reset asserted mid-run: immediate return to IDLE with reset values; no done pulse.
- All outputs are registered; done is high exactly one cycle per terminated run.

Optional Feature:
- FST_RUN_CTRL_PC_TRACE_EN.
- Defined: adds input pc (32) and output halt_pc (32). halt_pc captures pc on the RUN->HALT or RUN->TMO transition, and is cleared to 0 by reset and by start acceptance.
- Undefined: neither port exists, and no capture logic is built.

Decomposition:
- Package fst_run_pkg: state enum run_state_t {IDLE, RESET, RUN, HALT, TMO}, CNT_W default, DEFAULT_TIMEOUT constant.
- One natural sub-module, fst_sat_counter (clear/enable/saturating counter, CNT_W wide), used for cycles. The hold counter stays inline.

Test Plan:
- Reset then start; is_halt rises 10 cycles after core_reset_n goes high -> core_reset_n low exactly 3 cycles, done pulse once, halted=1, cycles=10, core_reset_n remains 1.
- timeout_ld with timeout_val=20, start, is_halt held 0 -> TMO after 20 RUN cycles, timed_out=1, cycles=20, core_reset_n=0, single done.
- limit=5 and is_halt=1 on the cycle cycles==4 -> halted=1, timed_out=0.
- start pulsed during RUN, then is_halt held high during RESET of a fresh run -> first start ignored; stale halt ignored; halt only registers once RUN begins.
- reset asserted at cycles=7 in RUN -> next cycle IDLE, all outputs 0, no done; a following start runs normally.
- timeout_val=0, run 100 cycles, then halt -> no timeout, cycles=100; with FST_RUN_CTRL_PC_TRACE_EN defined and pc=32'h0000_0040 at halt -> halt_pc=32'h0000_0040.
